// File: rtl/jk_bank.sv
// WIDTH-bit JK register bank with hold/JK/load/up-down count modes; q updates one cycle after inputs are sampled.
// No backpressure; tc is combinational from q/up. Define JK_BANK_CHANGE_EN to add the registered per-bit change mask chg.
module jk_bank #(
  parameter int              WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             tc
`ifdef JK_BANK_CHANGE_EN
  ,
  output logic [WIDTH-1:0] chg
`endif
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_JK    = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_COUNT = 2'b11
  } mode_e;

  logic [WIDTH-1:0] cnt_tgl;
  logic [WIDTH-1:0] q_next;
  logic             carry;

  // Ripple toggle condition: bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    cnt_tgl = '0;
    carry   = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_tgl[i] = carry;
      carry      = carry & (up ? q[i] : ~q[i]);
    end
  end

  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = RESET_VAL;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_JK:    q_next = (j & ~q) | (~k & q);
        MODE_LOAD:  q_next = d;
        MODE_COUNT: q_next = q ^ cnt_tgl;
        default:    q_next = q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RESET_VAL;
    end else begin
      q <= q_next;
    end
  end

`ifdef JK_BANK_CHANGE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chg <= '0;
    end else begin
      chg <= q_next ^ q;
    end
  end
`endif

  assign tc = up ? (&q) : ~(|q);

endmodule

// File: tb/tb_jk_bank.sv
// Directed bench for jk_bank (WIDTH=8): reset, JK table, load/clear priority, count wrap, enable hold, reset mid-count.
module tb_jk_bank;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, clr, en, up;
  logic [1:0]   mode;
  logic [W-1:0] j, k, d;
  logic [W-1:0] q;
  logic         tc;
`ifdef JK_BANK_CHANGE_EN
  logic [W-1:0] chg;
`endif

  int total = 0;
  int bad   = 0;

  jk_bank #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (en),
    .mode  (mode),
    .j     (j),
    .k     (k),
    .d     (d),
    .up    (up),
    .q     (q),
    .tc    (tc)
`ifdef JK_BANK_CHANGE_EN
    ,
    .chg   (chg)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; en = 1'b0; up = 1'b0;
    mode = 2'b00; j = '0; k = '0; d = '0;

    // Asynchronous reset, mid-cycle before any edge
    #2 reset = 1'b1;
    #1;
    chk("reset_async_q", q, 8'h00);
    chk("reset_tc_down", tc, 1'b1);
    tick();
    reset = 1'b0;

    // JK truth table
    en = 1'b1; mode = 2'b01; j = 8'hF0; k = 8'h0F;
    tick(); chk("jk_set_clear", q, 8'hF0);
    chk("tc_not_zero", tc, 1'b0);
    j = 8'hFF; k = 8'hFF;
    tick(); chk("jk_toggle", q, 8'h0F);
    j = 8'h00; k = 8'h00;
    tick(); chk("jk_hold", q, 8'h0F);
    j = 8'hCC; k = 8'hAA;
    tick(); chk("jk_mixed", q, 8'hC5);

    // Load, then clear overrides en=0 and load
    mode = 2'b10; d = 8'hA5;
    tick(); chk("load_a5", q, 8'hA5);
    clr = 1'b1; en = 1'b0; d = 8'h3C;
    tick(); chk("clr_priority", q, 8'h00);
    clr = 1'b0; en = 1'b1;

    // Count up across wrap
    d = 8'hFE;
    tick(); chk("load_fe", q, 8'hFE);
    mode = 2'b11; up = 1'b1;
    tick(); chk("up_ff", q, 8'hFF); chk("up_tc_ff", tc, 1'b1);
    tick(); chk("up_wrap_00", q, 8'h00); chk("up_tc_00", tc, 1'b0);
    tick(); chk("up_01", q, 8'h01);

    // Count down across wrap
    mode = 2'b10; d = 8'h01;
    tick(); chk("load_01", q, 8'h01);
    mode = 2'b11; up = 1'b0;
    tick(); chk("dn_00", q, 8'h00); chk("dn_tc_00", tc, 1'b1);
    tick(); chk("dn_wrap_ff", q, 8'hFF); chk("dn_tc_ff", tc, 1'b0);
    tick(); chk("dn_fe", q, 8'hFE);

    // Enable low holds for three cycles, then mode 00 holds
    en = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick(); chk("en_hold", q, 8'hFE);
    end
    en = 1'b1; mode = 2'b00;
    tick(); chk("mode_hold", q, 8'hFE);

    // Reset in the middle of counting
    mode = 2'b10; d = 8'h10;
    tick(); chk("load_10", q, 8'h10);
    mode = 2'b11; up = 1'b1;
    tick(); chk("cnt_11", q, 8'h11);
    #2 reset = 1'b1;
    #1 chk("reset_midcount", q, 8'h00);
    tick();
    chk("reset_held", q, 8'h00);
    reset = 1'b0;
    tick(); chk("resume_01", q, 8'h01);
    tick(); chk("resume_02", q, 8'h02);

    // Change mask around a full JK toggle
    mode = 2'b10; d = 8'h0F;
    tick(); chk("load_0f", q, 8'h0F);
    mode = 2'b01; j = 8'hFF; k = 8'hFF;
    tick(); chk("jk_all_toggle", q, 8'hF0);
`ifdef JK_BANK_CHANGE_EN
    chk("chg_toggle", chg, 8'hFF);
`endif
    en = 1'b0;
    tick(); chk("en_off_hold", q, 8'hF0);
`ifdef JK_BANK_CHANGE_EN
    chk("chg_idle", chg, 8'h00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
